// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory read port, hazard/branch controls,
// and the IF/ID register contents presented to decode.
interface pc_fetch_unit_if;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        stall;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        id_valid;
   logic [63:0] id_pc;
   logic [31:0] id_instr;
   logic        halted;
   logic        misalign_err;

   modport master (
      output imem_addr, id_valid, id_pc, id_instr, halted, misalign_err,
      input  imem_instr, stall, redirect, redirect_pc
   );

   modport slave (
      input  imem_addr, id_valid, id_pc, id_instr, halted, misalign_err,
      output imem_instr, stall, redirect, redirect_pc
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// LEGv8 instruction fetch: owns the PC, reads instruction memory and fills
// the IF/ID register; handles stall, redirect, end-of-memory halt and misaligned trap.
module pc_fetch_unit #(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter int          MEM_BYTES = 128
) (
   input  logic            clk,
   input  logic            rst_n,
   pc_fetch_unit_if.master bus
);

   localparam logic [63:0] LAST_PC = 64'(MEM_BYTES - 4);

   typedef enum logic [1:0] {WAIT, FETCH, HALT} state_t;

   state_t      state;
   logic [63:0] pc;
   logic        vld_p1;
   logic [63:0] pc_p1;
   logic [31:0] instr_p1;
   logic        halted_q;
   logic        misalign_q;

   // A wrapped PC lands near 2^64 and is rejected here like any other overrun.
   function automatic logic past_end(input logic [63:0] addr);
      return addr > LAST_PC;
   endfunction

   function automatic logic misaligned(input logic [63:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

   // IF -> IF/ID boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= WAIT;
         pc         <= RESET_PC;
         vld_p1     <= 1'b0;
         pc_p1      <= 64'h0;
         instr_p1   <= 32'h0;
         halted_q   <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         case (state)
            WAIT: state <= FETCH;
            FETCH: begin
               if (bus.redirect) begin
                  vld_p1 <= 1'b0;
                  if (misaligned(bus.redirect_pc)) begin
                     misalign_q <= 1'b1;
                     halted_q   <= 1'b1;
                     state      <= HALT;
                  end else begin
                     pc <= bus.redirect_pc;
                  end
               end else if (bus.stall) begin
                  state <= FETCH;
               end else if (past_end(pc)) begin
                  vld_p1   <= 1'b0;
                  halted_q <= 1'b1;
                  state    <= HALT;
               end else begin
                  instr_p1 <= bus.imem_instr;
                  pc_p1    <= pc;
                  vld_p1   <= 1'b1;
                  pc       <= pc + 64'd4;
               end
            end
            HALT: vld_p1 <= 1'b0;
            default: begin
               vld_p1   <= 1'b0;
               halted_q <= 1'b1;
               state    <= HALT;
            end
         endcase
      end
   end

   assign bus.imem_addr    = pc;
   assign bus.id_valid     = vld_p1;
   assign bus.id_pc        = pc_p1;
   assign bus.id_instr     = instr_p1;
   assign bus.halted       = halted_q;
   assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus random stall/redirect traffic,
// every cycle compared against a behavioural fetch model.
module tb_pc_fetch_unit;

   localparam int MEM_BYTES = 128;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   pc_fetch_unit_if bif ();

   pc_fetch_unit #(.RESET_PC(64'h0), .MEM_BYTES(MEM_BYTES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [32];

   assign bif.imem_instr = (bif.imem_addr < 64'(MEM_BYTES)) ? mem[bif.imem_addr[6:2]] : 32'hDEADBEEF;

   // Reference model state
   int          m_mode;   // 0 settling, 1 running, 2 stopped
   logic [63:0] m_pc;
   logic        m_vld;
   logic [63:0] m_id_pc;
   logic [31:0] m_id_instr;
   logic        m_halted;
   logic        m_mis;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      if (a < 64'(MEM_BYTES)) return mem[int'(a >> 2)];
      return 32'hDEADBEEF;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_pc = 64'h0; m_vld = 1'b0; m_id_pc = 64'h0;
      m_id_instr = 32'h0; m_halted = 1'b0; m_mis = 1'b0;
   endtask

   task automatic model_edge(input logic s, input logic r, input logic [63:0] rpc);
      if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 2) begin
         m_vld = 1'b0;
      end else if (r) begin
         m_vld = 1'b0;
         if (rpc % 4 != 0) begin
            m_mis = 1'b1; m_halted = 1'b1; m_mode = 2;
         end else begin
            m_pc = rpc;
         end
      end else if (!s) begin
         if (m_pc + 4 > 64'(MEM_BYTES) || m_pc > 64'(MEM_BYTES)) begin
            m_vld = 1'b0; m_halted = 1'b1; m_mode = 2;
         end else begin
            m_id_instr = mem_word(m_pc);
            m_id_pc    = m_pc;
            m_vld      = 1'b1;
            m_pc       = m_pc + 64'd4;
         end
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".addr"},   bif.imem_addr,           m_pc);
      check({tag, ".valid"},  64'(bif.id_valid),       64'(m_vld));
      check({tag, ".id_pc"},  bif.id_pc,               m_id_pc);
      check({tag, ".instr"},  64'(bif.id_instr),       64'(m_id_instr));
      check({tag, ".halted"}, 64'(bif.halted),         64'(m_halted));
      check({tag, ".mis"},    64'(bif.misalign_err),   64'(m_mis));
   endtask

   // Called at posedge+1; inputs change away from the edge.
   task automatic step(input string tag, input logic s, input logic r, input logic [63:0] rpc);
      bif.stall = s; bif.redirect = r; bif.redirect_pc = rpc;
      @(posedge clk);
      model_edge(s, r, rpc);
      #1;
      compare_all(tag);
   endtask

   // Asserts reset between edges and checks it takes effect without a clock.
   task automatic pulse_reset(input string tag);
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all({tag, ".async"});
      @(posedge clk);
      #1;
      compare_all({tag, ".held"});
      rst_n = 1'b1;
   endtask

   initial begin
      logic [63:0] rpc;
      logic        s, r;
      int          n;

      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      mem[0] = 32'h8B1F03E5; mem[1] = 32'hF84000A4;
      mem[2] = 32'h8B040086; mem[3] = 32'hF80010A6;
      bif.stall = 1'b0; bif.redirect = 1'b0; bif.redirect_pc = 64'h0;
      model_reset();

      // 1. reset state, settle cycle, first fetches
      #12;
      compare_all("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      step("wait", 0, 0, 64'h0);
      check("wait.valid0", 64'(bif.id_valid), 64'h0);
      step("f0", 0, 0, 64'h0);
      check("f0.instr", 64'(bif.id_instr), 64'h8B1F03E5);
      step("f4", 0, 0, 64'h0);
      check("f4.instr", 64'(bif.id_instr), 64'hF84000A4);

      // 2. stall with pc=8
      for (int i = 0; i < 3; i++) begin
         step("stall", 1, 0, 64'h0);
         check("stall.id_pc", bif.id_pc, 64'h4);
         check("stall.instr", 64'(bif.id_instr), 64'hF84000A4);
         check("stall.addr", bif.imem_addr, 64'h8);
      end
      step("f8", 0, 0, 64'h0);
      check("f8.instr", 64'(bif.id_instr), 64'h8B040086);

      // 3. redirect to 0 at pc=12
      check("pre_redir.addr", bif.imem_addr, 64'hC);
      step("redir", 0, 1, 64'h0);
      check("redir.bubble", 64'(bif.id_valid), 64'h0);
      step("r0", 0, 0, 64'h0);
      check("r0.instr", 64'(bif.id_instr), 64'h8B1F03E5);
      step("r4", 0, 0, 64'h0);
      step("r8", 0, 0, 64'h0);
      step("r12", 0, 0, 64'h0);
      check("r12.instr", 64'(bif.id_instr), 64'hF80010A6);
      check("r12.id_pc", bif.id_pc, 64'hC);

      // 4. redirect beats stall
      step("redir_stall", 1, 1, 64'h40);
      check("rs.bubble", 64'(bif.id_valid), 64'h0);
      check("rs.addr", bif.imem_addr, 64'h40);

      // 5. run off the end of memory
      n = 0;
      while (!bif.halted && n < 100) begin
         step("run", 0, 0, 64'h0);
         n++;
      end
      check("halt.reached", 64'(bif.halted), 64'h1);
      check("halt.addr", bif.imem_addr, 64'd128);
      check("halt.valid", 64'(bif.id_valid), 64'h0);
      step("halt.redir", 0, 1, 64'h0);
      check("halt.ignored", bif.imem_addr, 64'd128);

      // 6. reset, misaligned redirect trap, mid-run reset
      pulse_reset("rst1");
      step("w2", 0, 0, 64'h0);
      step("g0", 0, 0, 64'h0);
      step("mis", 0, 1, 64'h6);
      check("mis.flag", 64'(bif.misalign_err), 64'h1);
      check("mis.halted", 64'(bif.halted), 64'h1);
      check("mis.addr", bif.imem_addr, 64'h4);
      pulse_reset("rst2");
      step("w3", 0, 0, 64'h0);
      step("g1", 0, 0, 64'h0);
      step("g2", 0, 0, 64'h0);
      pulse_reset("rst_mid");
      check("rst_mid.addr0", bif.imem_addr, 64'h0);

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         if ((m_mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
            pulse_reset("rnd_rst");
         end else begin
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 15))
               0:       rpc = 64'hFFFF_FFFF_FFFF_FFFC;
               1:       rpc = {57'($urandom_range(0, 31)), 5'b0, 2'($urandom_range(1, 3))};
               default: rpc = 64'($urandom_range(0, 33)) * 64'd4;
            endcase
            step("rnd", s, r, rpc);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
